// File: rtl/fetch_q_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_q_pkg;

    localparam int FQ_PC_W  = 9;
    localparam int FQ_INS_W = 32;

    localparam logic [31:0] FQ_BUBBLE = 32'h0;
    localparam int          PC_STEP   = 4;

    typedef struct packed {
        logic [FQ_PC_W-1:0]  pc;
        logic [FQ_INS_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// Ring buffer holding fetched {pc, instr} entries; combinational head read, flush clears pointers.
module fq_ring
    import fetch_q_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fq_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  entry_t                   wr_data,
    input  logic                     rd_en,
    output entry_t                   rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    // Payload storage carries no reset; validity is tracked solely by count_reg.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                mem[gi] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC generation, one in-flight imem request, and a small {pc, instr} queue.
// Optional FETCH_BYPASS_EN presents the returning fetch directly when the queue is empty.
module instr_fetch_queue
    import fetch_q_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INS_W-1:0]         imem_rdata,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     stall,
    input  logic                     halt,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INS_W-1:0]         out_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] fpc_reg;
    logic [PC_W-1:0] req_pc_reg;
    logic            req_v_reg;

    logic [CW-1:0]   count;
    logic [CW:0]     pending;
    entry_t          head;
    entry_t          fill_entry;
    entry_t          sel;
    logic            issue;
    logic            fill;
    logic            deq;
    logic            wr_en;
    logic            rd_en;
    logic            head_valid;

    // Counting the in-flight request reserves its slot, so a fill never overflows.
    assign pending    = {1'b0, count} + (CW+1)'(req_v_reg);
    assign issue      = !halt && !redirect && (pending < (CW+1)'(DEPTH));
    assign fill       = req_v_reg && !redirect;
    assign fill_entry = '{pc: req_pc_reg, instr: imem_rdata};
    assign imem_addr  = fpc_reg;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass     = (count == '0) && fill;
    assign head_valid = (count != '0) || bypass;
    assign sel        = bypass ? fill_entry : head;
    assign deq        = head_valid && !stall && !redirect;
    // A bypassed entry consumed immediately never touches the ring.
    assign wr_en      = fill && !(bypass && deq);
    assign rd_en      = deq && !bypass;
`else
    assign head_valid = (count != '0);
    assign sel        = head;
    assign deq        = head_valid && !stall && !redirect;
    assign wr_en      = fill;
    assign rd_en      = deq;
`endif

    fq_ring #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect),
        .wr_en   (wr_en),
        .wr_data (fill_entry),
        .rd_en   (rd_en),
        .rd_data (head),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc_reg    <= RESET_PC;
            req_pc_reg <= '0;
            req_v_reg  <= 1'b0;
        end else if (redirect) begin
            fpc_reg   <= redirect_pc;
            req_v_reg <= 1'b0;
        end else begin
            req_v_reg <= issue;
            if (issue) begin
                req_pc_reg <= fpc_reg;
                fpc_reg    <= fpc_reg + PC_W'(PC_STEP);
            end
        end
    end

    assign out_valid = head_valid;
    assign out_pc    = head_valid ? sel.pc : '0;
    assign out_instr = head_valid ? sel.instr : INS_W'(FQ_BUBBLE);
    assign occupancy = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; imem word i holds 0x1000+i with one-cycle read latency.
module tb_instr_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        stall;
    logic        halt;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [8:0]  exp_pc;
    logic [8:0]  p;
    logic [31:0] exp_ins;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= 32'h1000 + {25'b0, imem_addr[8:2]};

    instr_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .occupancy   (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (out_pc !== 9'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected 000", out_pc); end
        n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h expected 00000000", out_instr); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        n_cmp++; if (imem_addr !== 9'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 000", imem_addr); end
        $display("reset: valid=%0b occ=%0d addr=%h", out_valid, occupancy, imem_addr);
    endtask

    task automatic test_startup();
        reset = 1'b1; stall = 1'b0; halt = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL start_c0_valid: got %0b expected 0", out_valid); end
        for (int k = 1; k < LAT; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL start_early_valid: got %0b expected 0", out_valid); end
        end
        tick();
        for (int j = 0; j < 4; j++) begin
            p = 9'(4 * j);
            exp_ins = 32'h1000 + 32'(j);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL start_valid[%0d]: got %0b expected 1", j, out_valid); end
            n_cmp++; if (out_pc !== p) begin n_bad++; $display("FAIL start_pc[%0d]: got %h expected %h", j, out_pc, p); end
            n_cmp++; if (out_instr !== exp_ins) begin n_bad++; $display("FAIL start_instr[%0d]: got %h expected %h", j, out_instr, exp_ins); end
            $display("startup: pc=%h instr=%h", out_pc, out_instr);
            tick();
        end
        exp_pc = 9'h010;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL stall_occ: got %0d expected 4", occupancy); end
        n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL stall_head: got %h expected %h", out_pc, exp_pc); end
        p = exp_pc + 9'd16;
        n_cmp++; if (imem_addr !== p) begin n_bad++; $display("FAIL stall_addr: got %h expected %h", imem_addr, p); end
        tick();
        n_cmp++; if (imem_addr !== p) begin n_bad++; $display("FAIL stall_addr_frozen: got %h expected %h", imem_addr, p); end
        $display("stall: occ=%0d head=%h addr=%h", occupancy, out_pc, imem_addr);
        stall = 1'b0;
        for (int j = 0; j < 6; j++) begin
            exp_ins = 32'h1000 + {25'b0, exp_pc[8:2]};
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL release_valid[%0d]: got %0b expected 1", j, out_valid); end
            n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL release_pc[%0d]: got %h expected %h", j, out_pc, exp_pc); end
            n_cmp++; if (out_instr !== exp_ins) begin n_bad++; $display("FAIL release_instr[%0d]: got %h expected %h", j, out_instr, exp_ins); end
            $display("release: pc=%h instr=%h", out_pc, out_instr);
            exp_pc = exp_pc + 9'd4;
            tick();
        end
    endtask

    task automatic test_redirect(input logic [8:0] target, input string tag);
        stall = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        redirect = 1'b1; redirect_pc = target; stall = 1'b0;
        tick();
        redirect = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_flush_valid: got %0b expected 0", tag, out_valid); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL %s_flush_occ: got %0d expected 0", tag, occupancy); end
        n_cmp++; if (out_pc !== 9'h0) begin n_bad++; $display("FAIL %s_flush_pc: got %h expected 000", tag, out_pc); end
        for (int k = 1; k < LAT; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_gap_valid: got %0b expected 0", tag, out_valid); end
        end
        tick();
        exp_pc = target;
        for (int j = 0; j < 4; j++) begin
            exp_ins = 32'h1000 + {25'b0, exp_pc[8:2]};
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid[%0d]: got %0b expected 1", tag, j, out_valid); end
            n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL %s_pc[%0d]: got %h expected %h", tag, j, out_pc, exp_pc); end
            n_cmp++; if (out_instr !== exp_ins) begin n_bad++; $display("FAIL %s_instr[%0d]: got %h expected %h", tag, j, out_instr, exp_ins); end
            $display("%s: pc=%h instr=%h", tag, out_pc, out_instr);
            exp_pc = exp_pc + 9'd4;
            tick();
        end
    endtask

    task automatic fill_to_three(input string tag);
        bit found;
        found = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 10 && !found; k++) begin
            if (occupancy == 3'd3) found = 1'b1;
            else tick();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL %s_fill3: got occ %0d expected 3 within 10 cycles", tag, occupancy); end
    endtask

    task automatic test_halt();
        fill_to_three("halt");
        halt = 1'b1; stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL halt_drain_valid[%0d]: got %0b expected 1", j, out_valid); end
            n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL halt_drain_pc[%0d]: got %h expected %h", j, out_pc, exp_pc); end
            $display("halt drain: pc=%h", out_pc);
            exp_pc = exp_pc + 9'd4;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL halt_idle_valid[%0d]: got %0b expected 0", k, out_valid); end
            n_cmp++; if (imem_addr !== exp_pc) begin n_bad++; $display("FAIL halt_idle_addr[%0d]: got %h expected %h", k, imem_addr, exp_pc); end
            tick();
        end
        halt = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL resume_gap_valid: got %0b expected 0", out_valid); end
        end
        tick();
        for (int j = 0; j < 2; j++) begin
            n_cmp++; if (out_pc !== exp_pc || out_valid !== 1'b1) begin n_bad++; $display("FAIL resume_pc[%0d]: got %h/%0b expected %h/1", j, out_pc, out_valid, exp_pc); end
            $display("resume: pc=%h", out_pc);
            exp_pc = exp_pc + 9'd4;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        fill_to_three("rstmid");
        reset = 1'b0;
        tick();
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL rstmid_occ: got %0d expected 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (imem_addr !== 9'h0) begin n_bad++; $display("FAIL rstmid_addr: got %h expected 000", imem_addr); end
        $display("reset mid-stream: occ=%0d valid=%0b addr=%h", occupancy, out_valid, imem_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect(9'h040, "redirect");
        test_redirect(9'h1F8, "wrap");
        test_halt();
        test_reset_mid();
        test_startup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
